// File: rtl/dtw_ref_pkg.sv
// Shared state encodings and read-latency constants for the DTW reference store.
// DTW_REF_OUTREG_EN selects a registered BRAM read port (RL=2) instead of RL=1.
package dtw_ref_pkg;

  typedef enum logic [1:0] {
    LIdle,
    LLoad,
    LFull
  } load_st_e;

  typedef enum logic [1:0] {
    RIdle,
    RStream,
    RDrain
  } rd_st_e;

`ifdef DTW_REF_OUTREG_EN
  localparam int unsigned RL = 2;
`else
  localparam int unsigned RL = 1;
`endif

  // One slot per read in flight plus one, so a always-ready sink sees 1 sample/clk.
  localparam int unsigned FIFO_D = RL + 1;

endpackage

// File: rtl/dtw_ref_bram.sv
// Simple dual-port block RAM, one write and one read port.
// DTW_REF_OUTREG_EN adds an output register after the read register.
module dtw_ref_bram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PTR_W = 18
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**PTR_W];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

`ifdef DTW_REF_OUTREG_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    out_q <= rd_q;
  end

  assign rd_data = out_q;
`else
  assign rd_data = rd_q;
`endif

endmodule

// File: rtl/dtw_ref_stream_mem.sv
// Reference store for the DTW core: stream load into BRAM, credit-paced stream readout.
// Read latency and output FIFO depth follow DTW_REF_OUTREG_EN (see dtw_ref_pkg).
module dtw_ref_stream_mem
  import dtw_ref_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PTR_W = 18,
  parameter int unsigned LEN_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_clr,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic             loaded,
  output logic [LEN_W-1:0] ref_len,
  output logic             ovf_err,
  input  logic             rd_start,
  output logic             rd_busy,
  output logic             rd_done,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int unsigned DEPTH = 2**PTR_W;
  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
  localparam int unsigned IDX_W = $clog2(FIFO_D);

  load_st_e         l_state_q, l_state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             loaded_q, loaded_d;
  logic [LEN_W-1:0] ref_len_q, ref_len_d;
  logic             ovf_q, ovf_d;

  rd_st_e           r_state_q, r_state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic             rd_done_q, rd_done_d;

  logic [RL-1:0]    vld_pipe_q, lst_pipe_q;

  logic [WIDTH-1:0] fifo_data_q [FIFO_D];
  logic             fifo_last_q [FIFO_D];
  logic [IDX_W-1:0] fifo_wr_q, fifo_rd_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  logic             start_ok, clr_ok, s_hs, mem_we, m_hs, issue, issue_last, fifo_push;
  logic [PTR_W-1:0] rd_addr;
  logic [LEN_W-1:0] end_addr;
  logic [WIDTH-1:0] bram_rd_data;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(FIFO_D - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign rd_busy  = (r_state_q != RIdle);
  // rd_start wins over a same-cycle load_clr; load_clr is ignored while streaming.
  assign start_ok = rd_start & (r_state_q == RIdle) & loaded_q;
  assign clr_ok   = load_clr & ~rd_busy & ~start_ok;
  assign s_ready  = (l_state_q == LLoad) & ~rd_busy;
  assign s_hs     = s_valid & s_ready;
  assign mem_we   = s_hs & ~clr_ok;

  assign m_valid  = (fifo_cnt_q != '0);
  assign m_data   = m_valid ? fifo_data_q[fifo_rd_q] : '0;
  assign m_last   = m_valid & fifo_last_q[fifo_rd_q];
  assign m_hs     = m_valid & m_ready;

  // The first read goes out in the rd_start cycle itself; a credit freed this
  // cycle by a handshake may be spent immediately.
  assign issue      = start_ok |
                      ((r_state_q == RStream) & ((credits_q != '0) | m_hs) &
                       (issued_q < ref_len_q));
  assign rd_addr    = (r_state_q == RIdle) ? '0 : rd_ptr_q;
  assign end_addr   = ref_len_q - LEN_W'(1);
  assign issue_last = (LEN_W'(rd_addr) == end_addr);
  assign fifo_push  = vld_pipe_q[RL-1];

  assign loaded  = loaded_q;
  assign ref_len = ref_len_q;
  assign ovf_err = ovf_q;
  assign rd_done = rd_done_q;

  always_comb begin
    l_state_d = l_state_q;
    wr_ptr_d  = wr_ptr_q;
    loaded_d  = loaded_q;
    ref_len_d = ref_len_q;
    ovf_d     = ovf_q;
    case (l_state_q)
      LIdle, LFull, LLoad: begin
        if (clr_ok) begin
          l_state_d = LLoad;
          wr_ptr_d  = '0;
          loaded_d  = 1'b0;
          ref_len_d = '0;
          ovf_d     = 1'b0;
        end else if ((l_state_q == LLoad) && s_hs) begin
          if (s_last) begin
            ref_len_d = LEN_W'(wr_ptr_q) + LEN_W'(1);
            loaded_d  = 1'b1;
            l_state_d = LFull;
          end else if (wr_ptr_q == '1) begin
            ref_len_d = LEN_W'(DEPTH);
            ovf_d     = 1'b1;
            loaded_d  = 1'b1;
            l_state_d = LFull;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      default: l_state_d = LIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_ptr_d  = rd_ptr_q;
    issued_d  = issued_q;
    rd_done_d = 1'b0;
    credits_d = credits_q - CNT_W'(issue) + CNT_W'(m_hs);
    case (r_state_q)
      RIdle: begin
        if (start_ok) begin
          r_state_d = RStream;
          issued_d  = LEN_W'(1);
          rd_ptr_d  = (ref_len_q > LEN_W'(1)) ? PTR_W'(1) : '0;
        end
      end
      RStream: begin
        if (issue) begin
          issued_d = issued_q + LEN_W'(1);
          if (LEN_W'(rd_ptr_q) != end_addr) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
        if (issued_q == ref_len_q) begin
          r_state_d = RDrain;
        end
      end
      RDrain: begin
        if (m_hs && m_last) begin
          r_state_d = RIdle;
          rd_done_d = 1'b1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state_q  <= LIdle;
      wr_ptr_q   <= '0;
      loaded_q   <= 1'b0;
      ref_len_q  <= '0;
      ovf_q      <= 1'b0;
      r_state_q  <= RIdle;
      rd_ptr_q   <= '0;
      issued_q   <= '0;
      credits_q  <= CNT_W'(FIFO_D);
      rd_done_q  <= 1'b0;
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      l_state_q  <= l_state_d;
      wr_ptr_q   <= wr_ptr_d;
      loaded_q   <= loaded_d;
      ref_len_q  <= ref_len_d;
      ovf_q      <= ovf_d;
      r_state_q  <= r_state_d;
      rd_ptr_q   <= rd_ptr_d;
      issued_q   <= issued_d;
      credits_q  <= credits_d;
      rd_done_q  <= rd_done_d;
      vld_pipe_q[0] <= issue;
      lst_pipe_q[0] <= issue_last;
      for (int i = 1; i < RL; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        lst_pipe_q[i] <= lst_pipe_q[i-1];
      end
      if (fifo_push) begin
        fifo_wr_q <= next_idx(fifo_wr_q);
      end
      if (m_hs) begin
        fifo_rd_q <= next_idx(fifo_rd_q);
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(m_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[fifo_wr_q] <= bram_rd_data;
      fifo_last_q[fifo_wr_q] <= lst_pipe_q[RL-1];
    end
  end

  dtw_ref_bram #(
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_bram (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (s_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (bram_rd_data)
  );

endmodule

// File: tb/tb_dtw_ref_stream_mem.sv
// Directed bench for dtw_ref_stream_mem at PTR_W=3: load table plus readout sequences.
module tb_dtw_ref_stream_mem;

`ifdef DTW_REF_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, load_clr, s_valid, s_ready, s_last, loaded, ovf_err;
  logic        rd_start, rd_busy, rd_done, m_valid, m_ready, m_last;
  logic [15:0] s_data, m_data;
  logic [3:0]  ref_len;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic        last;
    logic [15:0] data;
    logic        e_rdy;
    logic        e_loaded;
    logic [3:0]  e_len;
    logic        e_ovf;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  dtw_ref_stream_mem #(
    .WIDTH (16),
    .PTR_W (3),
    .LEN_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_clr (load_clr),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .loaded   (loaded),
    .ref_len  (ref_len),
    .ovf_err  (ovf_err),
    .rd_start (rd_start),
    .rd_busy  (rd_busy),
    .rd_done  (rd_done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic clr, input logic vld, input logic last,
                      input logic [15:0] d, input logic er, input logic el,
                      input logic [3:0] len, input logic eo);
    tbl[i].clr = clr;  tbl[i].vld = vld;     tbl[i].last = last;  tbl[i].data = d;
    tbl[i].e_rdy = er; tbl[i].e_loaded = el; tbl[i].e_len = len;  tbl[i].e_ovf = eo;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      load_clr = tbl[i].clr;
      s_valid  = tbl[i].vld;
      s_last   = tbl[i].last;
      s_data   = tbl[i].data;
      chk($sformatf("v%0d_s_ready", i), int'(s_ready), int'(tbl[i].e_rdy));
      chk($sformatf("v%0d_loaded", i), int'(loaded), int'(tbl[i].e_loaded));
      chk($sformatf("v%0d_ref_len", i), int'(ref_len), int'(tbl[i].e_len));
      chk($sformatf("v%0d_ovf_err", i), int'(ovf_err), int'(tbl[i].e_ovf));
      tick();
    end
    load_clr = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
  endtask

  // mode 0: sink always ready; 1: random m_ready; 2: load_clr+rd_start pulsed mid-stream.
  task automatic run_read(input int n, input logic [15:0] base, input int mode);
    int          k = 0;
    int          cyc = 0;
    int          first = -1;
    bit          stall_prev = 0;
    logic [15:0] held_d = '0;
    logic        held_l = 1'b0;
    rd_start = 1'b1;
    m_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    chk("busy_before_start", int'(rd_busy), 0);
    tick();
    rd_start = 1'b0;
    cyc = 1;
    while (k < n && cyc < 100) begin
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      load_clr = (mode == 2 && cyc == 3);
      rd_start = (mode == 2 && cyc == 3);
      chk("busy_in_stream", int'(rd_busy), 1);
      if (mode == 2) chk("s_ready_in_stream", int'(s_ready), 0);
      if (stall_prev) begin
        chk("stall_valid_held", int'(m_valid), 1);
        chk("stall_data_held", int'(m_data), int'(held_d));
        chk("stall_last_held", int'(m_last), int'(held_l));
      end
      if (m_valid && first < 0) begin
        first = cyc;
        chk("first_valid_latency", cyc, LAT);
      end
      if (m_valid && m_ready) begin
        chk($sformatf("m_data_%0d", k), int'(m_data), int'(base) + k);
        chk($sformatf("m_last_%0d", k), int'(m_last), (k == n - 1) ? 1 : 0);
        if (mode == 0) chk($sformatf("back_to_back_%0d", k), cyc, LAT + k);
        k++;
      end
      stall_prev = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
      tick();
      cyc++;
    end
    load_clr = 1'b0;
    rd_start = 1'b0;
    chk("read_sample_count", k, n);
    chk("rd_done_pulse", int'(rd_done), 1);
    chk("busy_at_done", int'(rd_busy), 0);
    chk("valid_after_stream", int'(m_valid), 0);
    tick();
    chk("rd_done_cleared", int'(rd_done), 0);
  endtask

  initial begin
    int k;
    int cyc;
    rst = 1'b1; load_clr = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    rd_start = 1'b0; m_ready = 1'b0;

    // Load of 0x0011..0x0015.
    setv(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      setv(1 + i, 1'b0, 1'b1, (i == 4), 16'h0011 + 16'(i), 1'b1, 1'b0, 4'd0, 1'b0);
    setv(6, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd5, 1'b0);
    // Overflow: 9 pushes into an 8-deep store.
    setv(7, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 8; i++)
      setv(8 + i, 1'b0, 1'b1, 1'b0, 16'h0021 + 16'(i), 1'b1, 1'b0, 4'd0, 1'b0);
    setv(16, 1'b0, 1'b1, 1'b0, 16'h0029, 1'b0, 1'b1, 4'd8, 1'b1);
    setv(17, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd8, 1'b1);
    // load_clr clears the sticky overflow.
    setv(18, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 4'd8, 1'b1);
    setv(19, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);

    tick();
    tick();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_rd_busy", int'(rd_busy), 0);
    rst = 1'b0;

    apply(0, 6);
    run_read(5, 16'h0011, 0);
    for (int r = 0; r < 3; r++) run_read(5, 16'h0011, 1);
    run_read(5, 16'h0011, 2);
    chk("loaded_after_ignored_clr", int'(loaded), 1);
    chk("len_after_ignored_clr", int'(ref_len), 5);

    apply(7, 17);
    run_read(8, 16'h0021, 0);
    apply(18, 19);

    // Reload three samples, then reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_last = (i == 2); s_data = 16'h0031 + 16'(i);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("reload3_len", int'(ref_len), 3);
    rd_start = 1'b1; m_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 50) begin
      if (m_valid) begin
        chk($sformatf("pre_rst_data_%0d", k), int'(m_data), 16'h0031 + k);
        k++;
      end
      tick();
      cyc++;
    end
    chk("pre_rst_count", k, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_loaded", int'(loaded), 0);
    chk("mid_rst_ref_len", int'(ref_len), 0);
    chk("mid_rst_ovf_err", int'(ovf_err), 0);
    chk("mid_rst_rd_busy", int'(rd_busy), 0);
    chk("mid_rst_rd_done", int'(rd_done), 0);
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_m_last", int'(m_last), 0);
    chk("mid_rst_m_data", int'(m_data), 0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("start_unloaded_busy", int'(rd_busy), 0);
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("start_unloaded_valid", int'(m_valid), 0);

    // Single-sample reference.
    load_clr = 1'b1;
    tick();
    load_clr = 1'b0;
    s_valid = 1'b1; s_last = 1'b1; s_data = 16'h0044;
    chk("len1_s_ready", int'(s_ready), 1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("len1_loaded", int'(loaded), 1);
    chk("len1_ref_len", int'(ref_len), 1);
    run_read(1, 16'h0044, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
